// File: rtl/prim_ram_rd_stream_if.sv
// prim_ram_rd_stream_if: burst command, RAM read port and output stream bundle
interface prim_ram_rd_stream_if #(
    parameter int Width = 32,
    parameter int Aw    = 7
);
    logic             start_i;
    logic [Aw-1:0]    base_i;
    logic [Aw:0]      len_i;
    logic             busy_o;
    logic             done_o;
    logic             ram_req_o;
    logic             ram_write_o;
    logic [Aw-1:0]    ram_addr_o;
    logic [Width-1:0] ram_wdata_o;
    logic [Width-1:0] ram_rdata_i;
    logic             rd_valid_o;
    logic             rd_ready_i;
    logic [Width-1:0] rd_data_o;
    logic             rd_last_o;

    modport master (
        input  start_i, base_i, len_i, ram_rdata_i, rd_ready_i,
        output busy_o, done_o, ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o,
               rd_valid_o, rd_data_o, rd_last_o
    );

    modport slave (
        output start_i, base_i, len_i, ram_rdata_i, rd_ready_i,
        input  busy_o, done_o, ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o,
               rd_valid_o, rd_data_o, rd_last_o
    );
endinterface

// File: rtl/prim_ram_rd_stream.sv
// prim_ram_rd_stream: burst reader from a 1-cycle-latency RAM port into a valid/ready stream
module prim_ram_rd_stream #(
    parameter int Width = 32,
    parameter int Depth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    prim_ram_rd_stream_if.master bus
);
    localparam int Aw = $clog2(Depth);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e           state, state_n;
    logic [Aw-1:0]    addr;
    logic [Aw:0]      issue_cnt, pop_cnt;
    logic             inflight;
    logic [Width-1:0] mem [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;
    logic             issue, pop, push, done;
    logic [2:0]       occ;

    assign push = inflight;
    assign pop  = (count != 2'd0) & bus.rd_ready_i;
    // Words held plus the one in flight; a same-cycle pop frees a credit.
    assign occ  = {1'b0, count} + {2'b0, inflight};

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (bus.start_i) state_n = (bus.len_i != '0) ? RUN : DRAIN;
            RUN: begin
                issue = (occ < 3'd2) || (occ == 3'd2 && pop);
                if (issue && issue_cnt == (Aw+1)'(1)) state_n = DRAIN;
            end
            DRAIN: begin
                done = (count == 2'd0) && !inflight && (pop_cnt == '0);
                if (done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            addr      <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            state    <= state_n;
            inflight <= issue;
            if (state == IDLE && bus.start_i) begin
                addr      <= bus.base_i;
                issue_cnt <= bus.len_i;
                pop_cnt   <= bus.len_i;
            end
            if (issue) begin
                addr      <= (addr == Aw'(Depth - 1)) ? '0 : addr + Aw'(1);
                issue_cnt <= issue_cnt - (Aw+1)'(1);
            end
            if (push) begin
                mem[wr_ptr] <= bus.ram_rdata_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                pop_cnt <= pop_cnt - (Aw+1)'(1);
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.busy_o      = state != IDLE;
    assign bus.done_o      = done;
    assign bus.ram_req_o   = issue;
    assign bus.ram_write_o = 1'b0;
    assign bus.ram_addr_o  = addr;
    assign bus.ram_wdata_o = '0;
    assign bus.rd_valid_o  = count != 2'd0;
    assign bus.rd_data_o   = mem[rd_ptr];
    assign bus.rd_last_o   = bus.rd_valid_o && (pop_cnt == (Aw+1)'(1));
endmodule

// File: tb/tb_prim_ram_rd_stream.sv
// tb_prim_ram_rd_stream: directed scenario tests against a 1-cycle RAM model
module tb_prim_ram_rd_stream;
    localparam int Width = 32;
    localparam int Depth = 128;
    localparam int Aw    = 7;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [Width-1:0] ram [Depth];

    prim_ram_rd_stream_if #(.Width(Width), .Aw(Aw)) bus ();
    prim_ram_rd_stream #(.Width(Width), .Depth(Depth)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (bus.ram_req_o) bus.ram_rdata_i <= ram[bus.ram_addr_o];

    // Drive a command so the current cycle is cycle 0.
    task automatic cycle_start(input logic [Aw-1:0] b, input logic [Aw:0] l);
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.base_i  = b;
        bus.len_i   = l;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    function automatic logic rdy(input int c);
        return (c < 6) ? c[0] : (c < 16) ? 1'b0 : 1'b1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        checks += 9;
        if (bus.busy_o !== 1'b0)      begin errors++; $display("FAIL %s busy got %b exp 0", tag, bus.busy_o); end
        if (bus.done_o !== 1'b0)      begin errors++; $display("FAIL %s done got %b exp 0", tag, bus.done_o); end
        if (bus.ram_req_o !== 1'b0)   begin errors++; $display("FAIL %s req got %b exp 0", tag, bus.ram_req_o); end
        if (bus.ram_addr_o !== '0)    begin errors++; $display("FAIL %s addr got %0d exp 0", tag, bus.ram_addr_o); end
        if (bus.rd_valid_o !== 1'b0)  begin errors++; $display("FAIL %s valid got %b exp 0", tag, bus.rd_valid_o); end
        if (bus.rd_last_o !== 1'b0)   begin errors++; $display("FAIL %s last got %b exp 0", tag, bus.rd_last_o); end
        if (bus.rd_data_o !== '0)     begin errors++; $display("FAIL %s data got %0h exp 0", tag, bus.rd_data_o); end
        if (bus.ram_write_o !== 1'b0) begin errors++; $display("FAIL %s write got %b exp 0", tag, bus.ram_write_o); end
        if (bus.ram_wdata_o !== '0)   begin errors++; $display("FAIL %s wdata got %0h exp 0", tag, bus.ram_wdata_o); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.base_i = '0;
        bus.len_i = '0;
        bus.rd_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
    endtask

    // Ready held high: exact cycle-by-cycle timing for base/len.
    task automatic test_burst(input string tag, input int base, input int len);
        cycle_start(Aw'(base), (Aw+1)'(len));
        for (int c = 0; c <= len + 5; c++) begin
            logic        exp_req, exp_valid;
            logic [Aw-1:0] exp_addr;
            logic [Width-1:0] exp_data;
            @(negedge clk);
            exp_req   = (c >= 1) && (c <= len);
            exp_valid = (c >= 3) && (c <= len + 2);
            exp_addr  = Aw'((base + c - 1) % Depth);
            exp_data  = 32'h100 + 32'((base + c - 3) % Depth);
            checks += 4;
            if (bus.ram_req_o !== exp_req) begin errors++; $display("FAIL %s req c%0d got %b exp %b", tag, c, bus.ram_req_o, exp_req); end
            if (bus.rd_valid_o !== exp_valid) begin errors++; $display("FAIL %s valid c%0d got %b exp %b", tag, c, bus.rd_valid_o, exp_valid); end
            if (bus.done_o !== (c == len + 3)) begin errors++; $display("FAIL %s done c%0d got %b exp %b", tag, c, bus.done_o, c == len + 3); end
            if (bus.busy_o !== (c >= 1 && c <= len + 3)) begin errors++; $display("FAIL %s busy c%0d got %b", tag, c, bus.busy_o); end
            if (exp_req) begin
                checks++;
                if (bus.ram_addr_o !== exp_addr) begin errors++; $display("FAIL %s addr c%0d got %0d exp %0d", tag, c, bus.ram_addr_o, exp_addr); end
            end
            if (exp_valid) begin
                checks += 2;
                if (bus.rd_data_o !== exp_data) begin errors++; $display("FAIL %s data c%0d got %0h exp %0h", tag, c, bus.rd_data_o, exp_data); end
                if (bus.rd_last_o !== (c == len + 2)) begin errors++; $display("FAIL %s last c%0d got %b exp %b", tag, c, bus.rd_last_o, c == len + 2); end
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        logic hold = 1'b0;
        logic done_seen = 1'b0;
        logic [Width-1:0] hold_data = '0;
        cycle_start(Aw'(0), (Aw+1)'(8));
        bus.rd_ready_i = rdy(0);
        for (int c = 0; c < 60 && !done_seen; c++) begin
            @(negedge clk);
            if (hold) begin
                checks++;
                if (!bus.rd_valid_o || bus.rd_data_o !== hold_data) begin errors++; $display("FAIL bp_hold c%0d got %0h exp %0h", c, bus.rd_data_o, hold_data); end
            end
            if (c >= 9 && c < 16) begin
                checks++;
                if (bus.ram_req_o !== 1'b0) begin errors++; $display("FAIL bp_stall_req c%0d got %b exp 0", c, bus.ram_req_o); end
            end
            if (bus.rd_valid_o && bus.rd_ready_i) begin
                checks += 2;
                if (bus.rd_data_o !== 32'h100 + 32'(k)) begin errors++; $display("FAIL bp_data k%0d got %0h exp %0h", k, bus.rd_data_o, 32'h100 + 32'(k)); end
                if (bus.rd_last_o !== (k == 7)) begin errors++; $display("FAIL bp_last k%0d got %b exp %b", k, bus.rd_last_o, k == 7); end
                k++;
            end
            hold = bus.rd_valid_o && !bus.rd_ready_i;
            hold_data = bus.rd_data_o;
            if (bus.done_o) done_seen = 1'b1;
            next_cycle();
            bus.rd_ready_i = rdy(c + 1);
        end
        bus.rd_ready_i = 1'b1;
        checks += 2;
        if (k != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", k); end
        if (!done_seen) begin errors++; $display("FAIL bp_done got 0 exp 1"); end
    endtask

    task automatic test_zero_len();
        int k = 0;
        int dones = 0;
        cycle_start(Aw'(5), (Aw+1)'(0));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks += 4;
            if (bus.ram_req_o !== 1'b0) begin errors++; $display("FAIL zero_req c%0d got %b exp 0", c, bus.ram_req_o); end
            if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL zero_valid c%0d got %b exp 0", c, bus.rd_valid_o); end
            if (bus.done_o !== (c == 1)) begin errors++; $display("FAIL zero_done c%0d got %b exp %b", c, bus.done_o, c == 1); end
            if (bus.busy_o !== (c == 1)) begin errors++; $display("FAIL zero_busy c%0d got %b exp %b", c, bus.busy_o, c == 1); end
            next_cycle();
        end
        cycle_start(Aw'(20), (Aw+1)'(3));
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (bus.rd_valid_o && bus.rd_ready_i) begin
                checks++;
                if (bus.rd_data_o !== 32'h114 + 32'(k)) begin errors++; $display("FAIL ign_data k%0d got %0h exp %0h", k, bus.rd_data_o, 32'h114 + 32'(k)); end
                k++;
            end
            if (bus.done_o) dones++;
            next_cycle();
            if (c + 1 == 2) begin
                bus.start_i = 1'b1;
                bus.base_i  = Aw'(40);
                bus.len_i   = (Aw+1)'(5);
            end
        end
        checks += 3;
        if (k != 3) begin errors++; $display("FAIL ign_count got %0d exp 3", k); end
        if (dones != 1) begin errors++; $display("FAIL ign_dones got %0d exp 1", dones); end
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ign_busy got %b exp 0", bus.busy_o); end
    endtask

    task automatic test_reset_mid();
        cycle_start(Aw'(0), (Aw+1)'(6));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                checks++;
                if (bus.rd_data_o !== 32'h100 + 32'(c - 3) || !bus.rd_valid_o) begin errors++; $display("FAIL rmid_data c%0d got %0h exp %0h", c, bus.rd_data_o, 32'h100 + 32'(c - 3)); end
            end
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("rmid");
        for (int c = 7; c < 10; c++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_stale c%0d got %b exp 0", c, bus.rd_valid_o); end
        end
    endtask

    initial begin
        for (int i = 0; i < Depth; i++) ram[i] = 32'h100 + 32'(i);
        test_reset();
        test_burst("basic", 10, 4);
        test_backpressure();
        test_burst("wrap", 126, 4);
        test_zero_len();
        test_reset_mid();
        test_burst("fresh", 0, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
